// File: rtl/syn_gpu_anti_alias.sv
// Anti-alias stage: blends each incoming pixel with the framebuffer pixel by
// distance weight (read-modify-write through the pixel gateway); d==0 writes directly.
module syn_gpu_anti_alias #(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int LUM_W      = 4,
  parameter int CHRM_W     = 2,
  parameter int DIST_W     = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                      clk_ir,
  input  logic                      rst_sync_l,
  input  logic                      en,
  input  logic                      err_clr,
  input  logic [LUM_W+2*CHRM_W-1:0] in_pxl,
  input  logic                      in_pxl_wr_valid,
  input  logic                      in_pxl_rd_valid,
  input  logic [X_W-1:0]            in_posx,
  input  logic [Y_W-1:0]            in_posy,
  input  logic [DIST_W-1:0]         in_dist,
  input  logic [DIST_W-1:0]         in_norm,
  output logic                      in_ready,
  output logic [LUM_W+2*CHRM_W-1:0] gw_tx_pxl,
  output logic                      gw_tx_wr_valid,
  output logic                      gw_tx_rd_valid,
  output logic [X_W-1:0]            gw_tx_posx,
  output logic [Y_W-1:0]            gw_tx_posy,
  input  logic                      gw_tx_ready,
  input  logic [LUM_W+2*CHRM_W-1:0] gw_rx_pxl,
  input  logic                      gw_rx_rd_valid,
  output logic                      gw_rx_ready,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int PXL_W = LUM_W + 2*CHRM_W;
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, BLEND, WR} state_t;

  state_t             state_reg;
  logic [PXL_W-1:0]   pxl_reg;
  logic [PXL_W-1:0]   old_reg;
  logic [DIST_W-1:0]  dist_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [PXL_W-1:0]   tx_pxl_reg;
  logic [X_W-1:0]     posx_reg;
  logic [Y_W-1:0]     posy_reg;
  logic               wr_valid_reg;
  logic               rd_valid_reg;
  logic               rx_ready_reg;
  logic               busy_reg;
  logic               err_reg;
  logic [DIST_W:0]    w_new;
  logic [PXL_W-1:0]   blend_pxl;
  logic               unused_inputs;

  assign unused_inputs = ^{in_pxl_rd_valid, in_norm};

  // Weight of the new pixel: 2^DIST_W - d (needs one extra bit for d==0)
  assign w_new = {1'b1, {DIST_W{1'b0}}} - {1'b0, dist_reg};

  // Channel 0 is lum (MSBs), 1 is cb, 2 is cr
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    localparam int CW  = (gi == 0) ? LUM_W : CHRM_W;
    localparam int LSB = (gi == 0) ? 2*CHRM_W : ((gi == 1) ? CHRM_W : 0);
    localparam int MW  = CW + DIST_W + 1;
    logic [MW-1:0] mix;
    assign mix = MW'(pxl_reg[LSB +: CW]) * MW'(w_new)
               + MW'(old_reg[LSB +: CW]) * MW'(dist_reg);
    assign blend_pxl[LSB +: CW] = CW'(mix >> DIST_W);
  end

  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      state_reg    <= IDLE;
      pxl_reg      <= '0;
      old_reg      <= '0;
      dist_reg     <= '0;
      cnt_reg      <= '0;
      tx_pxl_reg   <= '0;
      posx_reg     <= '0;
      posy_reg     <= '0;
      wr_valid_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rx_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      // A timeout later in this block overrides the clear
      if (err_clr) err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en && in_pxl_wr_valid) begin
            pxl_reg  <= in_pxl;
            posx_reg <= in_posx;
            posy_reg <= in_posy;
            dist_reg <= in_dist;
            busy_reg <= 1'b1;
            if (in_dist == '0) begin
              tx_pxl_reg   <= in_pxl;
              wr_valid_reg <= 1'b1;
              state_reg    <= WR;
            end else begin
              rd_valid_reg <= 1'b1;
              state_reg    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (gw_tx_ready) begin
            rd_valid_reg <= 1'b0;
            rx_ready_reg <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (gw_rx_rd_valid) begin
            old_reg      <= gw_rx_pxl;
            rx_ready_reg <= 1'b0;
            state_reg    <= BLEND;
          end else if (cnt_reg == CNT_W'(RD_TIMEOUT)) begin
            old_reg      <= '0;
            err_reg      <= 1'b1;
            rx_ready_reg <= 1'b0;
            state_reg    <= BLEND;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BLEND: begin
          tx_pxl_reg   <= blend_pxl;
          wr_valid_reg <= 1'b1;
          state_reg    <= WR;
        end
        WR: begin
          if (gw_tx_ready) begin
            wr_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_reg == IDLE) && en;
  assign gw_tx_pxl      = tx_pxl_reg;
  assign gw_tx_wr_valid = wr_valid_reg;
  assign gw_tx_rd_valid = rd_valid_reg;
  assign gw_tx_posx     = posx_reg;
  assign gw_tx_posy     = posy_reg;
  assign gw_rx_ready    = rx_ready_reg;
  assign busy           = busy_reg;
  assign err_timeout    = err_reg;

endmodule

// File: tb/tb_syn_gpu_anti_alias.sv
// Bench for syn_gpu_anti_alias: directed pixels, expected gateway writes queued
// and checked by a monitor on every write handshake.
module tb_syn_gpu_anti_alias;

  logic       clk_ir = 1'b0;
  logic       rst_sync_l = 1'b0;
  logic       en = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] in_pxl = '0;
  logic       in_pxl_wr_valid = 1'b0;
  logic       in_pxl_rd_valid = 1'b0;
  logic [9:0] in_posx = '0;
  logic [8:0] in_posy = '0;
  logic [3:0] in_dist = '0;
  logic [3:0] in_norm = '0;
  logic       in_ready;
  logic [7:0] gw_tx_pxl;
  logic       gw_tx_wr_valid;
  logic       gw_tx_rd_valid;
  logic [9:0] gw_tx_posx;
  logic [8:0] gw_tx_posy;
  logic       gw_tx_ready = 1'b1;
  logic [7:0] gw_rx_pxl = '0;
  logic       gw_rx_rd_valid = 1'b0;
  logic       gw_rx_ready;
  logic       busy;
  logic       err_timeout;

  syn_gpu_anti_alias dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l), .en(en), .err_clr(err_clr),
    .in_pxl(in_pxl), .in_pxl_wr_valid(in_pxl_wr_valid), .in_pxl_rd_valid(in_pxl_rd_valid),
    .in_posx(in_posx), .in_posy(in_posy), .in_dist(in_dist), .in_norm(in_norm),
    .in_ready(in_ready), .gw_tx_pxl(gw_tx_pxl), .gw_tx_wr_valid(gw_tx_wr_valid),
    .gw_tx_rd_valid(gw_tx_rd_valid), .gw_tx_posx(gw_tx_posx), .gw_tx_posy(gw_tx_posy),
    .gw_tx_ready(gw_tx_ready), .gw_rx_pxl(gw_rx_pxl), .gw_rx_rd_valid(gw_rx_rd_valid),
    .gw_rx_ready(gw_rx_ready), .busy(busy), .err_timeout(err_timeout)
  );

  initial forever #5 clk_ir = ~clk_ir;

  typedef struct packed {
    logic [7:0] pxl;
    logic [9:0] x;
    logic [8:0] y;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: condition not reached within cycle budget", name);
  endtask

  // Monitor: every accepted gateway write is compared against the queue head
  always @(negedge clk_ir) begin
    if (rst_sync_l) begin
      if (gw_tx_rd_valid && gw_tx_ready) rd_cnt++;
      if (gw_tx_wr_valid && gw_tx_ready) begin
        wr_t e;
        wr_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("wr_unexpected");
        end else begin
          e = exp_q.pop_front();
          check("wr_pxl_pos", {5'd0, gw_tx_pxl, gw_tx_posx, gw_tx_posy}, {5'd0, e});
        end
      end
    end
  end

  // sel: 0 = gw_rx_ready, 1 = gw_tx_wr_valid, 2 = not busy
  task automatic wait_for(input int sel, input int budget, input string name);
    int n = 0;
    logic c;
    c = (sel == 0) ? gw_rx_ready : (sel == 1) ? gw_tx_wr_valid : !busy;
    while (!c && n < budget) begin
      @(posedge clk_ir); #1;
      n++;
      c = (sel == 0) ? gw_rx_ready : (sel == 1) ? gw_tx_wr_valid : !busy;
    end
    if (!c) fail_now(name);
  endtask

  task automatic send_pixel(input logic [7:0] p, input logic [9:0] x, input logic [8:0] y,
                            input logic [3:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk_ir); #1;
      n++;
    end
    if (!in_ready) fail_now("accept");
    in_pxl = p; in_posx = x; in_posy = y; in_dist = d;
    in_pxl_wr_valid = 1'b1;
    @(posedge clk_ir); #1;
    in_pxl_wr_valid = 1'b0;
  endtask

  // Waits for RD_WAIT, lets `delay` edges pass, then presents one response
  task automatic serve_read(input logic [7:0] old, input int delay);
    wait_for(0, 50, "rd_wait_entry");
    repeat (delay) @(posedge clk_ir);
    #1;
    gw_rx_pxl = old;
    gw_rx_rd_valid = 1'b1;
    @(posedge clk_ir); #1;
    gw_rx_rd_valid = 1'b0;
  endtask

  initial begin
    int rd0, wr0;
    #2;
    check("rst_outputs", {gw_tx_wr_valid, gw_tx_rd_valid, gw_rx_ready, busy, err_timeout}, 5'b0);
    check("rst_pos_pxl", {gw_tx_pxl, gw_tx_posx, gw_tx_posy}, 27'd0);
    check("rst_in_ready", in_ready, 1'b1);
    #10 rst_sync_l = 1'b1;
    @(posedge clk_ir); #1;

    // Bypass: written one cycle after accept, no read
    rd0 = rd_cnt;
    exp_q.push_back('{pxl: 8'hFF, x: 10'd5, y: 9'd7});
    send_pixel(8'hFF, 10'd5, 9'd7, 4'd0);
    check("byp_wr_valid", {gw_tx_wr_valid, gw_tx_rd_valid}, 2'b10);
    check("byp_data", {gw_tx_pxl, gw_tx_posx, gw_tx_posy}, {8'hFF, 10'd5, 9'd7});
    @(posedge clk_ir); #1;
    check("byp_in_ready_back", in_ready, 1'b1);
    check("byp_no_read", rd_cnt - rd0, 0);

    // Blend d=4: lum 15/0 -> 11, cb 3/1 -> 2, cr 0/3 -> 0
    exp_q.push_back('{pxl: 8'hB8, x: 10'd20, y: 9'd30});
    send_pixel(8'hFC, 10'd20, 9'd30, 4'd4);
    check("bl_rd_valid", {gw_tx_rd_valid, gw_tx_posx, gw_tx_posy}, {1'b1, 10'd20, 9'd30});
    serve_read(8'h07, 3);
    check("bl_blend_cycle", {gw_tx_wr_valid, busy}, 2'b01);
    @(posedge clk_ir); #1;
    check("bl_wr_cycle", {gw_tx_wr_valid, gw_tx_pxl}, {1'b1, 8'hB8});
    @(posedge clk_ir); #1;
    check("bl_idle", in_ready, 1'b1);

    // Blend d=8: lum 7, cb 2, cr 1
    exp_q.push_back('{pxl: 8'h79, x: 10'd1023, y: 9'd511});
    send_pixel(8'hFC, 10'd1023, 9'd511, 4'd8);
    serve_read(8'h07, 0);
    wait_for(2, 20, "d8_done");

    // Backpressure on both read and write requests
    rd0 = rd_cnt; wr0 = wr_cnt;
    gw_tx_ready = 1'b0;
    exp_q.push_back('{pxl: 8'hB8, x: 10'd100, y: 9'd200});
    send_pixel(8'hFC, 10'd100, 9'd200, 4'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp_rd_hold", {gw_tx_rd_valid, gw_tx_posx, gw_tx_posy, in_ready},
            {1'b1, 10'd100, 9'd200, 1'b0});
      @(posedge clk_ir); #1;
    end
    gw_tx_ready = 1'b1;
    @(posedge clk_ir); #1;
    gw_tx_ready = 1'b0;
    serve_read(8'h07, 1);
    wait_for(1, 20, "bp_wr_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_wr_hold", {gw_tx_wr_valid, gw_tx_pxl, gw_tx_posx, gw_tx_posy, in_ready},
            {1'b1, 8'hB8, 10'd100, 9'd200, 1'b0});
      @(posedge clk_ir); #1;
    end
    gw_tx_ready = 1'b1;
    wait_for(2, 20, "bp_done");
    check("bp_one_rd_one_wr", {rd_cnt - rd0, wr_cnt - wr0}, {32'd1, 32'd1});

    // Timeout: old forced to 0, lum 15 d=4 -> 11
    check("to_err_before", err_timeout, 1'b0);
    exp_q.push_back('{pxl: 8'hB0, x: 10'd9, y: 9'd9});
    send_pixel(8'hF0, 10'd9, 9'd9, 4'd4);
    wait_for(1, 400, "to_wr_valid");
    check("to_err_set", err_timeout, 1'b1);
    wait_for(2, 20, "to_done");
    check("to_err_sticky", err_timeout, 1'b1);
    err_clr = 1'b1;
    @(posedge clk_ir); #1;
    err_clr = 1'b0;
    check("to_err_clr", err_timeout, 1'b0);

    // Response on the same cycle the count reaches the limit wins
    exp_q.push_back('{pxl: 8'hF0, x: 10'd11, y: 9'd12});
    send_pixel(8'hF0, 10'd11, 9'd12, 4'd4);
    serve_read(8'hFF, 255);
    wait_for(2, 20, "edge_done");
    check("edge_no_err", err_timeout, 1'b0);

    // Enable dropped mid-read: pixel completes, then no accept
    exp_q.push_back('{pxl: 8'hB8, x: 10'd40, y: 9'd41});
    send_pixel(8'hFC, 10'd40, 9'd41, 4'd4);
    wait_for(0, 50, "en_rd_wait");
    en = 1'b0;
    serve_read(8'h07, 2);
    wait_for(2, 20, "en_done");
    in_pxl_wr_valid = 1'b1;
    repeat (3) @(posedge clk_ir);
    #1;
    check("en_off_no_accept", {in_ready, busy}, 2'b00);
    in_pxl_wr_valid = 1'b0;
    en = 1'b1;

    // Stray read response in IDLE
    gw_rx_pxl = 8'h33;
    gw_rx_rd_valid = 1'b1;
    @(posedge clk_ir); #1;
    gw_rx_rd_valid = 1'b0;
    @(posedge clk_ir); #1;
    check("stray_ignored", {busy, gw_rx_ready, gw_tx_rd_valid, gw_tx_wr_valid, in_ready}, 5'b00001);

    // Reset during RD_WAIT drops the pixel
    send_pixel(8'hFC, 10'd50, 9'd60, 4'd4);
    wait_for(0, 50, "rst_rd_wait");
    rst_sync_l = 1'b0;
    #1;
    check("rst_mid_ctl", {gw_tx_wr_valid, gw_tx_rd_valid, gw_rx_ready, busy, err_timeout, in_ready},
          6'b000001);
    check("rst_mid_data", {gw_tx_pxl, gw_tx_posx, gw_tx_posy}, 27'd0);
    @(posedge clk_ir); #1;
    rst_sync_l = 1'b1;
    exp_q.push_back('{pxl: 8'h5A, x: 10'd3, y: 9'd4});
    send_pixel(8'h5A, 10'd3, 9'd4, 4'd0);
    wait_for(2, 20, "post_rst_done");

    repeat (3) @(posedge clk_ir);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/syn_gpu_anti_alias.md
# syn_gpu_anti_alias

Anti-alias stage of the grapheme GPU. It sits directly downstream of the GPU core's anti-alias pixel port, where the euclid engine streams pixel writes tagged with a distance-from-ideal-line value. For each pixel, the block reads the current framebuffer pixel through the pixel gateway, blends old and new pixels per channel by distance weight, and writes the result back. A distance of 0 bypasses the read and writes directly.

## Interface
Parameters:
- X_W, 10, pixel X coordinate width
- Y_W, 9, pixel Y coordinate width
- LUM_W, 4, luminance channel width
- CHRM_W, 2, width of each chroma channel (Cb, Cr)
- DIST_W, 4, distance/weight width
- RD_TIMEOUT, 255, max cycles waiting for a gateway read response

Ports (PXL_W = LUM_W+2*CHRM_W; packing is {lum, cb, cr}, lum at MSB):
- clk_ir  in  1  clock; one clock domain
- rst_sync_l  in  1  reset; asynchronous, active-low
- en  in  1  stage enable (driven from GPU control enable)
- err_clr  in  1  clears err_timeout
- in_pxl  in  PXL_W  new pixel colour
- in_pxl_wr_valid  in  1  pixel write request
- in_pxl_rd_valid  in  1  not supported; ignored
- in_posx / in_posy  in  X_W / Y_W  pixel position
- in_dist  in  DIST_W  blend weight d (0 = on-line)
- in_norm  in  DIST_W  ignored in this revision
- in_ready  out  1  stage can accept a pixel
- gw_tx_pxl  out  PXL_W  write data to gateway
- gw_tx_wr_valid / gw_tx_rd_valid  out  1  gateway write / read request
- gw_tx_posx / gw_tx_posy  out  X_W / Y_W  gateway address
- gw_tx_ready  in  1  gateway accepts request
- gw_rx_pxl  in  PXL_W  read response data
- gw_rx_rd_valid  in  1  read response valid
- gw_rx_ready  out  1  stage can take a read response
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky read-timeout flag

## Operation
- **FSM states:** IDLE, RD_REQ, RD_WAIT, BLEND, WR.
- **in_ready:** combinational, = (state==IDLE) & en.
- **Accept:** occurs on in_ready & in_pxl_wr_valid. Capture pxl, posx, posy and dist.
  - d==0: go to WR.
  - Otherwise: go to RD_REQ.
- **RD_REQ:** gw_tx_rd_valid=1 with the captured position. When gw_tx_ready is sampled high, go to RD_WAIT.
- **RD_WAIT:** gw_rx_ready=1 and a wait counter increments.
  - On gw_rx_rd_valid: capture gw_rx_pxl as old and go to BLEND.
  - When the counter reaches RD_TIMEOUT: set old=0, set err_timeout, and go to BLEND.
- **BLEND:** one cycle. For each channel c: out_c = (new_c*(2^DIST_W − d) + old_c*d) >> DIST_W.
  - Intermediate width is W_c+DIST_W+1.
  - Result is truncated, not rounded. No overflow is possible.
- **WR:** gw_tx_wr_valid=1 with the captured position and gw_tx_pxl = blended pixel (or the raw pixel when d==0). Hold until gw_tx_ready is sampled high, then go to IDLE.
- **Request holding:** gw_tx_* requests and data stay stable while valid is high and ready is low.
- **Stray responses:** gw_rx_rd_valid outside RD_WAIT is ignored, and gw_rx_ready=0 there.
- **en deasserted mid-pixel:** the current pixel completes; no new accept occurs until en=1.
- **Error flag:** err_timeout is sticky. err_clr clears it. If err_clr and a new timeout occur in the same cycle, set wins.

## Timing
- **Reset values:** all registered outputs are 0, state is IDLE, and the counter is 0. in_ready = en after reset.
- **Reset mid-operation:** returns to IDLE within the reset; the in-flight pixel is dropped and no partial gateway request remains asserted.
- **Bypass (d==0):** accept at cycle N, gw_tx_wr_valid at N+1. With gw_tx_ready=1, in_ready is back at N+2.
- **Blend (d>0):** accept at N; gw_tx_rd_valid at N+1. Response at cycle R gives BLEND at R+1, gw_tx_wr_valid at R+2, and IDLE at R+3 if gw_tx_ready=1.
- **Timeout:** counter starts at 0 on entering RD_WAIT. A response in the same cycle as the count reaching RD_TIMEOUT takes priority (no error).
- **Throughput:** at most one pixel in flight; no pipelining across pixels.
- All outputs except in_ready are registered.

## Test plan
- **Bypass:** en=1; pixel 0xFF at (5,7), d=0, gw_tx_ready=1 → gw_tx_wr_valid one cycle later at (5,7) with 0xFF; no read is issued.
- **Blend:** new lum=15, cb=3, cr=0; old lum=0, cb=1, cr=3; d=4 → written lum=11, cb=2, cr=0 (180>>4, 40>>4, 12>>4). With d=8 and cb new=3, old=1 → cb=2.
- **Backpressure:** gw_tx_ready=0 for 5 cycles in both RD_REQ and WR → valid, position and data are held stable; exactly one read and one write are issued; in_ready stays 0 throughout.
- **Timeout:** no response for RD_TIMEOUT cycles, new lum=15, d=4 → err_timeout=1, written lum=11 (old=0). err_clr pulse → err_timeout=0.
- **Enable/stray:** en dropped mid-RD_WAIT → the pixel completes, then in_ready=0. A stray gw_rx_rd_valid in IDLE → no state change.
- **Reset mid-operation:** rst_sync_l asserted in RD_WAIT → all outputs 0 and IDLE. After release, a d=0 pixel completes normally.
